// File: rtl/cts_pkg.sv
// Shared constants and modular time helper for the cts event scheduler.
package cts_pkg;

    localparam int CTS_TW = 64;

    // Modulo-2^TW difference a - b, read as a signed distance.
    function automatic logic signed [CTS_TW-1:0] cts_sched_diff_t(
        input logic [CTS_TW-1:0] a,
        input logic [CTS_TW-1:0] b
    );
        return signed'(a - b);
    endfunction

endpackage

// File: rtl/cts_sched_fifo.sv
// In-order entry queue for cts_sched; exposes head, tail key and fill level.
module cts_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 80,
    parameter int KW    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [KW-1:0]            tail_key,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] tptr;
    logic          do_push;
    logic          do_pop;

    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign tptr     = wptr - AW'(1);
    assign head     = mem[rptr];
    // Key occupies the most significant bits of each entry.
    assign tail_key = mem[tptr][W-1 -: KW];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/cts_sched.sv
// Timestamp event scheduler with a two-stage due compare against cts.
// Build option: CTS_SCHED_LATE_DROP_EN drops late events and counts them.
module cts_sched
    import cts_pkg::*;
#(
    parameter int TW    = CTS_TW,
    parameter int GW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TW-1:0]            cts,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [TW-1:0]            s_ts,
    input  logic [GW-1:0]            s_tag,
    input  logic                     flush,
    output logic                     evt_valid,
    output logic [GW-1:0]            evt_tag,
    output logic                     evt_late,
    output logic                     evt_miss,
    output logic [15:0]              miss_cnt,
    output logic                     err_order,
    output logic [$clog2(DEPTH):0]   level
);

    typedef struct packed {
        logic [TW-1:0] ts;
        logic [GW-1:0] tag;
    } entry_t;

    entry_t        head;
    entry_t        wr;
    logic [TW-1:0] tail_ts;
    logic          full;
    logic          empty;
    logic [TW-1:0] odiff;
    logic [TW-1:0] diff_n;
    logic [TW-1:0] diff;
    logic          va;
    logic          order_bad;
    logic          push;
    logic          due;
    logic          late;

    assign s_ready   = !rst && !full && !flush;
    assign odiff     = TW'(cts_sched_diff_t(CTS_TW'(s_ts), CTS_TW'(tail_ts)));
    assign diff_n    = TW'(cts_sched_diff_t(CTS_TW'(cts), CTS_TW'(head.ts)));
    assign order_bad = !empty && odiff[TW-1];
    assign push      = s_valid && s_ready && !order_bad;
    assign due       = va && !diff[TW-1] && !flush;
    assign late      = diff != '0;
    assign wr        = '{ts: s_ts, tag: s_tag};

    cts_sched_fifo #(
        .DEPTH (DEPTH),
        .W     (TW + GW),
        .KW    (TW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .wdata    (wr),
        .pop      (due),
        .head     (head),
        .tail_key (tail_ts),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    // Stage A: va drops for a cycle after every pop so the new head is re-sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff      <= '0;
            va        <= 1'b0;
            evt_tag   <= '0;
            err_order <= 1'b0;
        end else begin
            diff <= diff_n;
            va   <= !empty && !due && !flush;
            if (due) begin
                evt_tag <= head.tag;
            end
            if (flush) begin
                err_order <= 1'b0;
            end else if (s_valid && s_ready && order_bad) begin
                err_order <= 1'b1;
            end
        end
    end

`ifdef CTS_SCHED_LATE_DROP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_late  <= 1'b0;
            evt_miss  <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            evt_valid <= due && !late;
            evt_late  <= 1'b0;
            evt_miss  <= due && late;
            if (flush) begin
                miss_cnt <= '0;
            end else if (due && late && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_late  <= 1'b0;
        end else begin
            evt_valid <= due;
            evt_late  <= due && late;
        end
    end

    assign evt_miss = 1'b0;
    assign miss_cnt = '0;
`endif

endmodule
